// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns an LSU access into a valid/ready bus request,
// stalls the pipeline until the response (or a timeout) arrives, and returns the read word.
module dmem_bus_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] data_addr,
    input  logic [3:0]  dmem_wr,
    input  logic [31:0] datamem_wr_o,
    input  logic        mem_rd,
    output logic [31:0] datamem_rd_in,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic        bus_rsp_err,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        is_store;
    logic        acc;

    assign is_store      = |dmem_wr;
    assign acc           = mem_rd | is_store;
    assign stall_o       = acc & (state != DONE);
    assign datamem_rd_in = rdata_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            rdata_q       <= 32'd0;
            bus_err_o     <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_addr      <= 32'd0;
            bus_we        <= 1'b0;
            bus_be        <= 4'd0;
            bus_wdata     <= 32'd0;
        end else begin
            bus_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (acc) begin
                        // a store takes priority over a simultaneous load
                        bus_addr      <= {data_addr[31:2], 2'b00};
                        bus_we        <= is_store;
                        bus_be        <= is_store ? dmem_wr : 4'b1111;
                        bus_wdata     <= datamem_wr_o;
                        bus_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (bus_req_ready) begin
                        bus_req_valid <= 1'b0;
                        cnt           <= 8'd0;
                        state         <= RSP;
                    end
                end
                RSP: begin
                    cnt <= cnt + 8'd1;
                    if (bus_rsp_valid) begin
                        rdata_q   <= (bus_rsp_err || bus_we) ? 32'd0 : bus_rdata;
                        bus_err_o <= bus_rsp_err;
                        state     <= DONE;
                    end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        // no response within the window: complete as an error
                        rdata_q   <= 32'd0;
                        bus_err_o <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Self-checking bench for dmem_bus_ctrl: a randomized bus responder plus a
// transaction-level model of stall length, request fields, error pulse and read data.
module tb_dmem_bus_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] data_addr, datamem_wr_o, datamem_rd_in, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  dmem_wr, bus_be;
    logic        mem_rd, stall_o, bus_err_o, bus_req_valid, bus_req_ready, bus_we;
    logic        bus_rsp_valid, bus_rsp_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_model = 32'd0;

    dmem_bus_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rstn(rstn), .data_addr(data_addr), .dmem_wr(dmem_wr),
        .datamem_wr_o(datamem_wr_o), .mem_rd(mem_rd), .datamem_rd_in(datamem_rd_in),
        .stall_o(stall_o), .bus_err_o(bus_err_o), .bus_req_valid(bus_req_valid),
        .bus_req_ready(bus_req_ready), .bus_addr(bus_addr), .bus_we(bus_we),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid),
        .bus_rsp_err(bus_rsp_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Stalled cycles: one IDLE, one REQ per ready wait, one RSP per response wait;
    // a missing response is cut off after T cycles in RSP.
    function automatic int exp_stalls(input int rdy_d, input int rsp_d);
        return 3 + rdy_d + ((rsp_d >= T) ? T - 1 : rsp_d);
    endfunction

    // Drives one access and acts as the bus slave; returns what it observed.
    task automatic access(
        input  logic [31:0] a_in, input logic [3:0] wr_in, input logic [31:0] wd_in,
        input  logic rd_in, input int rdy_d, input int rsp_d, input logic e_in,
        input  logic [31:0] rdat, input bit junk,
        output int stalls, output int vcyc, output logic [31:0] o_addr, output logic o_we,
        output logic [3:0] o_be, output logic [31:0] o_wd, output bit stable,
        output int errs, output logic err_done, output logic [31:0] rd_done, output bit hung);
        int  cyc, vw, rw;
        bit  ph_rsp, seen, fin;
        cyc = 0; vw = 0; rw = 0; ph_rsp = 0; seen = 0; fin = 0;
        stalls = 0; vcyc = -1; stable = 1; errs = 0; err_done = 1'bx; rd_done = 'x;
        o_addr = 'x; o_we = 1'bx; o_be = 'x; o_wd = 'x;
        data_addr = a_in; dmem_wr = wr_in; datamem_wr_o = wd_in; mem_rd = rd_in;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            if (bus_err_o) errs++;
            if (!stall_o) begin
                fin = 1; err_done = bus_err_o; rd_done = datamem_rd_in;
            end else begin
                stalls++;
                if (bus_req_valid) begin
                    if (!seen) begin
                        seen = 1; vcyc = cyc;
                        o_addr = bus_addr; o_we = bus_we; o_be = bus_be; o_wd = bus_wdata;
                    end else if (bus_addr !== o_addr || bus_we !== o_we ||
                                 bus_be !== o_be || bus_wdata !== o_wd) begin
                        stable = 0;
                    end
                    bus_req_ready = (vw == rdy_d);
                    if (vw == rdy_d) ph_rsp = 1;
                    vw++;
                    if (junk) begin
                        bus_rsp_valid = 1'b1; bus_rsp_err = 1'($urandom); bus_rdata = $urandom;
                    end
                end else if (ph_rsp) begin
                    if (rw == rsp_d) begin
                        bus_rsp_valid = 1'b1; bus_rsp_err = e_in; bus_rdata = rdat;
                    end
                    rw++;
                end
            end
            @(posedge clk); #1;
            bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; bus_rdata = $urandom;
            cyc++;
        end
        hung = !fin;
    endtask

    task automatic idle(input int n);
        data_addr = $urandom; dmem_wr = 4'd0; mem_rd = 1'b0; datamem_wr_o = $urandom;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (stall_o !== 1'b0 || bus_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_quiet: stall=%b valid=%b required 0/0", stall_o, bus_req_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; mem_rd = 1'b1; dmem_wr = 4'd0; data_addr = 32'h1234_5678;
        datamem_wr_o = 32'hFFFF_FFFF; bus_req_ready = 0; bus_rsp_valid = 0;
        bus_rsp_err = 0; bus_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL reset_stall: got %b required 1", stall_o);
        end
        checks++;
        if ({bus_req_valid, bus_we, bus_be, bus_addr, bus_wdata, datamem_rd_in, bus_err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b we=%b be=%h addr=%h wd=%h rd=%h err=%b required all 0",
                     bus_req_valid, bus_we, bus_be, bus_addr, bus_wdata, datamem_rd_in, bus_err_o);
        end
        @(posedge clk); #1;
        rstn = 1'b1; mem_rd = 1'b0;
        idle(2);
    endtask

    task automatic test_load_word;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        access(32'h1004, 4'd0, 32'h0, 1'b1, 0, 0, 1'b0, 32'hDEAD_BEEF, 0,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        rd_model = 32'hDEAD_BEEF;
        checks++;
        if (h || st != 3) begin errors++; $display("FAIL load_stall: got %0d hung=%0d required 3", st, h); end
        checks++;
        if (a !== 32'h1004 || be !== 4'b1111 || we !== 1'b0) begin
            errors++; $display("FAIL load_fields: addr=%h be=%b we=%b required 1004/1111/0", a, be, we);
        end
        checks++;
        if (rd !== 32'hDEAD_BEEF || ed !== 1'b0) begin
            errors++; $display("FAIL load_data: rd=%h err=%b required deadbeef/0", rd, ed);
        end
        idle(1);
    endtask

    task automatic test_byte_store;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        access(32'h2003, 4'b1000, 32'hAB00_0000, 1'b0, 2, 0, 1'b0, 32'h5555_5555, 0,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        rd_model = 32'd0;
        checks++;
        if (h || st != 5) begin errors++; $display("FAIL store_stall: got %0d hung=%0d required 5", st, h); end
        checks++;
        if (a !== 32'h2000 || be !== 4'b1000 || we !== 1'b1 || wd !== 32'hAB00_0000) begin
            errors++;
            $display("FAIL store_fields: addr=%h be=%b we=%b wd=%h required 2000/1000/1/ab000000", a, be, we, wd);
        end
        checks++;
        if (!sb) begin errors++; $display("FAIL store_stable: fields changed while waiting for ready, required stable"); end
        checks++;
        if (rd !== 32'd0 || er != 0) begin
            errors++; $display("FAIL store_done: rd=%h errs=%0d required 0/0", rd, er);
        end
        idle(1);
    endtask

    task automatic test_error;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        access(32'h3008, 4'd0, 32'h0, 1'b1, 1, 1, 1'b1, 32'hCAFE_F00D, 0,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        rd_model = 32'd0;
        checks++;
        if (h || st != 5) begin errors++; $display("FAIL err_stall: got %0d hung=%0d required 5", st, h); end
        checks++;
        if (rd !== 32'd0 || ed !== 1'b1 || er != 1) begin
            errors++; $display("FAIL err_pulse: rd=%h err_done=%b err_cycles=%0d required 0/1/1", rd, ed, er);
        end
        idle(1);
    endtask

    task automatic test_timeout;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        access(32'h400C, 4'd0, 32'h0, 1'b1, 0, 1000, 1'b0, 32'h1111_1111, 0,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        rd_model = 32'd0;
        checks++;
        if (h || st != 2 + T) begin
            errors++; $display("FAIL timeout_stall: got %0d hung=%0d required %0d", st, h, 2 + T);
        end
        checks++;
        if (rd !== 32'd0 || ed !== 1'b1 || er != 1) begin
            errors++; $display("FAIL timeout_err: rd=%h err_done=%b err_cycles=%0d required 0/1/1", rd, ed, er);
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        access(32'h5000, 4'd0, 32'h0, 1'b1, 2, 1, 1'b0, 32'h0BAD_CAFE, 1,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        checks++;
        if (h || st != 6 || vc != 1 || rd !== 32'h0BAD_CAFE || a !== 32'h5000 || we !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: stall=%0d vcyc=%0d rd=%h addr=%h we=%b required 6/1/0badcafe/5000/0",
                     st, vc, rd, a, we);
        end
        access(32'h6006, 4'b1100, 32'h1234_0000, 1'b1, 1, 0, 1'b0, 32'h7777_7777, 1,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        checks++;
        if (h || st != 4 || vc != 1 || a !== 32'h6004 || we !== 1'b1 || be !== 4'b1100 ||
            wd !== 32'h1234_0000 || rd !== 32'd0 || er != 0) begin
            errors++;
            $display("FAIL b2b_store: stall=%0d vcyc=%0d addr=%h we=%b be=%b wd=%h rd=%h errs=%0d required 4/1/6004/1/1100/12340000/0/0",
                     st, vc, a, we, be, wd, rd, er);
        end
        rd_model = 32'd0;
        idle(1);
    endtask

    task automatic test_random;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ad, wdat, rdat;
            logic [3:0]  wr;
            logic        ld, e, ex_we, ex_err;
            int          rdy_d, rsp_d;
            ad = $urandom; wdat = $urandom; rdat = $urandom;
            wr = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            ld = (wr == 4'd0) ? 1'b1 : 1'($urandom);
            rdy_d = $urandom_range(0, 3);
            rsp_d = $urandom_range(0, 5);
            e = ($urandom_range(0, 7) == 0);
            ex_we  = (wr != 4'd0);
            ex_err = (rsp_d >= T) || e;
            checks++;
            if (datamem_rd_in !== rd_model) begin
                errors++; $display("FAIL rnd_hold[%0d]: rd=%h required %h", i, datamem_rd_in, rd_model);
            end
            access(ad, wr, wdat, ld, rdy_d, rsp_d, e, rdat, 1'($urandom),
                   st, vc, a, we, be, wd, sb, er, ed, rd, h);
            rd_model = (ex_we || ex_err) ? 32'd0 : rdat;
            checks++;
            if (h || st != exp_stalls(rdy_d, rsp_d)) begin
                errors++;
                $display("FAIL rnd_stall[%0d]: got %0d hung=%0d required %0d", i, st, h, exp_stalls(rdy_d, rsp_d));
            end
            checks++;
            if (a !== {ad[31:2], 2'b00} || we !== ex_we || be !== (ex_we ? wr : 4'b1111) ||
                wd !== wdat || !sb) begin
                errors++;
                $display("FAIL rnd_fields[%0d]: addr=%h we=%b be=%b wd=%h stable=%0d required %h/%b/%b/%h/1",
                         i, a, we, be, wd, sb, {ad[31:2], 2'b00}, ex_we, ex_we ? wr : 4'b1111, wdat);
            end
            checks++;
            if (rd !== rd_model || ed !== ex_err || er != (ex_err ? 1 : 0)) begin
                errors++;
                $display("FAIL rnd_done[%0d]: rd=%h err=%b errs=%0d required %h/%b/%0d",
                         i, rd, ed, er, rd_model, ex_err, ex_err ? 1 : 0);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic test_reset_mid;
        int st, vc, er; logic [31:0] a, wd, rd; logic we, ed; logic [3:0] be; bit sb, h;
        int n;
        data_addr = 32'h7010; dmem_wr = 4'd0; mem_rd = 1'b1;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!bus_req_valid && n < 10);
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0; rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1; mem_rd = 1'b0;
        rd_model = 32'd0;
        @(negedge clk);
        checks++;
        if (bus_req_valid !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: valid=%b stall=%b required 0/0", bus_req_valid, stall_o);
        end
        bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_err_o !== 1'b0 || datamem_rd_in !== 32'd0 || bus_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale: err=%b rd=%h valid=%b required 0/0/0", bus_err_o, datamem_rd_in, bus_req_valid);
        end
        @(posedge clk); #1;
        access(32'h8000, 4'd0, 32'h0, 1'b1, 0, 0, 1'b0, 32'h0123_4567, 0,
               st, vc, a, we, be, wd, sb, er, ed, rd, h);
        rd_model = 32'h0123_4567;
        checks++;
        if (h || st != 3 || rd !== 32'h0123_4567) begin
            errors++; $display("FAIL rst_mid_after: stall=%0d rd=%h required 3/01234567", st, rd);
        end
        idle(1);
    endtask

    initial begin
        test_reset;
        test_load_word;
        test_byte_store;
        test_error;
        test_timeout;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
